// File: rtl/fsm_seq_engine.sv
// Table-programmable Moore sequencer: each entry selects a condition bit, branches to
// one of two successors, drives a position code and holds for a programmable dwell.
module fsm_seq_engine #(
    parameter int N_STATES = 16,
    parameter int COND_W   = 8,
    parameter int POS_W    = 2,
    parameter int DWELL_W  = 4,
    parameter int CNT_W    = 16,
    localparam int SW      = (N_STATES > 1) ? $clog2(N_STATES) : 1,
    localparam int CSW     = (COND_W > 1) ? $clog2(COND_W) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               loop,
    input  logic [COND_W-1:0]  cond,
    input  logic               cfg_we,
    input  logic [SW-1:0]      cfg_addr,
    input  logic               cfg_uncond,
    input  logic [CSW-1:0]     cfg_sel,
    input  logic [SW-1:0]      cfg_nt,
    input  logic [SW-1:0]      cfg_nf,
    input  logic [POS_W-1:0]   cfg_pos,
    input  logic [DWELL_W-1:0] cfg_dwell,
    output logic               busy,
    output logic [SW-1:0]      state_idx,
    output logic [POS_W-1:0]   pos,
    output logic               done,
    output logic [CNT_W-1:0]   step_cnt,
    output logic               err
);

    typedef struct packed {
        logic               uncond;
        logic [CSW-1:0]     sel;
        logic [SW-1:0]      nt;
        logic [SW-1:0]      nf;
        logic [POS_W-1:0]   pos;
        logic [DWELL_W-1:0] dwell;
    } entry_t;

    typedef enum logic {IDLE, RUN} eng_t;

    localparam int                NS_I     = N_STATES;
    localparam int                CW_I     = COND_W;
    localparam logic [SW:0]       ST_LIM   = NS_I[SW:0];
    localparam logic [CSW:0]      COND_LIM = CW_I[CSW:0];
    localparam entry_t            ENT_RST  = entry_t'{1'b1, '0, '0, '0, '0, '0};

    entry_t               tbl [N_STATES];
    entry_t               wr_ent;
    entry_t               cur;
    entry_t               ent0;
    entry_t               tgt_ent;
    eng_t                 state;
    logic [DWELL_W-1:0]   dwell_cnt;
    logic                 sel_bad;
    logic                 take;
    logic [SW-1:0]        nxt;
    logic                 oor;
    logic [SW-1:0]        tgt;
    logic                 wrap;

    assign wr_ent = entry_t'{cfg_uncond, cfg_sel, cfg_nt, cfg_nf, cfg_pos, cfg_dwell};

    // Table: writes only land while idle; an out-of-range address is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_STATES; i++) tbl[i] <= ENT_RST;
        end else if (cfg_we && !busy && ({1'b0, cfg_addr} < ST_LIM)) begin
            tbl[cfg_addr] <= wr_ent;
        end
    end

    // state_idx is only ever loaded with in-range indices, so this read is safe.
    always_comb begin
        cur     = tbl[state_idx];
        sel_bad = !cur.uncond && ({1'b0, cur.sel} >= COND_LIM);
        take    = cur.uncond || (!sel_bad && cond[cur.sel]);
        nxt     = take ? cur.nt : cur.nf;
        oor     = sel_bad || ({1'b0, nxt} >= ST_LIM);
        tgt     = oor ? '0 : nxt;
        tgt_ent = tbl[tgt];
        wrap    = !oor && (nxt == '0);
        // A same-cycle write to entry 0 must be seen by the start it accompanies.
        ent0    = (cfg_we && cfg_addr == '0) ? wr_ent : tbl[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            state_idx <= '0;
            pos       <= '0;
            done      <= 1'b0;
            step_cnt  <= '0;
            err       <= 1'b0;
            dwell_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        state_idx <= '0;
                        pos       <= ent0.pos;
                        dwell_cnt <= ent0.dwell;
                        step_cnt  <= '0;
                        err       <= 1'b0;
                    end
                end
                RUN: begin
                    if (cfg_we) err <= 1'b1;
                    if (stop) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        state_idx <= '0;
                        pos       <= '0;
                        dwell_cnt <= '0;
                    end else if (dwell_cnt != '0) begin
                        dwell_cnt <= dwell_cnt - 1'b1;
                    end else begin
                        if (step_cnt != '1) step_cnt <= step_cnt + 1'b1;
                        if (oor) err <= 1'b1;
                        if (wrap) done <= 1'b1;
                        // Single-shot wrap finishes; step_cnt keeps its final count.
                        if (wrap && !loop) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            state_idx <= '0;
                            pos       <= '0;
                            dwell_cnt <= '0;
                        end else begin
                            state_idx <= tgt;
                            pos       <= tgt_ent.pos;
                            dwell_cnt <= tgt_ent.dwell;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
